rps_frame_classifier: RTL and testbench
=======================================

# rps_frame_classifier

- Parametrised, single-clock successor to the serial HSV hand-mask classifier.
- Receives a bit-serial HSV pixel stream from the Raspberry Pi and synchronises it into `fpga_clk`; this replaces the divided-clock sampling.
- Thresholds each pixel into a ROWS×COLS hand mask and accumulates features while pixels stream in.
- Runs a sequential transition scan, then presents a rock/paper/scissors result with a valid/ready handshake and active-low breadboard drive.

## Interface
- ROWS, 40, mask rows (≥4)
- COLS, 60, mask columns (≥2)
- CH_BITS, 8, bits per H/S/V channel; pixel word = 3·CH_BITS
- HUE_MIN / HUE_MAX, 36 / 86, green-background hue band (inclusive)
- SAT_MIN / VAL_MIN, 25 / 25, background saturation/value floors (inclusive)
- LEFT_COLS, 24, columns [0, LEFT_COLS) counted for left sum
- SHIFT, 4, probe-column offset from leftmost hand pixel
- TRANS_TARGET, 4, transition count meaning scissors
- LEFT_THRESH, 48, left-sum threshold (strict >) meaning paper
- SYNC_STAGES, 2, synchroniser depth (≥2)
- fpga_clk  in  1  system clock, all state rises on it
- rst_n  in  1  asynchronous, active-low reset
- pi_clk  in  1  Pi serial clock, asynchronous to fpga_clk
- data_in  in  1  Pi serial data, asynchronous
- result_ready  in  1  consumer accepts result
- result  out  2  00 rock, 01 paper, 10 scissors
- result_valid  out  1  result held stable while high
- breadboard  out  3  active-low one-hot of last accepted result
- busy  out  1  high in SCAN or RESULT
- overrun  out  1  sticky: bit edge dropped

## Operation
- pi_clk and data_in each pass through SYNC_STAGES flops. A synchronised pi_clk 0→1 edge is one bit event; data_in is taken from the same sync stage.
- States:
  - RECV: bits enter the pixel buffer LSB-first, into bit index 0..3·CH_BITS−1. The last bit completes the pixel.
  - SCAN: entered after pixel ROWS·COLS−1 is written.
  - RESULT: entered after the scan.
- Pixel fields: hue [CH_BITS−1:0], sat [2·CH_BITS−1:CH_BITS], val [3·CH_BITS−1:2·CH_BITS].
- mask = NOT(hue in band AND sat≥SAT_MIN AND val≥VAL_MIN).
- mask[row][col] is written with row-major raster order; col wraps at COLS−1 to 0 and row increments.
- Streaming features:
  - sum_left += mask when col<LEFT_COLS. Width $clog2(ROWS·LEFT_COLS+1); saturation is not needed.
  - leftmost = min col with mask=1. Reset and frame-start value is COLS−1.
- SCAN:
  - probe p = min(leftmost+SHIFT, COLS−1).
  - For i = 2..ROWS−2, one i per cycle, trans += (mask[i][p] ≠ mask[i+1][p]).
  - trans width $clog2(ROWS).
- Classification: trans==TRANS_TARGET → 10; else sum_left>LEFT_THRESH → 01; else 00.
- RESULT:
  - result_valid=1 until a cycle with result_ready=1.
  - On that cycle, breadboard updates: 00→110, 01→101, 10→011.
  - Then return to RECV with mask, counters, buffer and features cleared.
- Bit events in SCAN/RESULT are discarded and set overrun. overrun clears only on reset.
- A frame with no hand pixels gives leftmost=COLS−1 and p=COLS−1; the frame is still classified.

## Timing
- Reset (async assert, sync release):
  - result=00, result_valid=0, breadboard=111, busy=0, overrun=0.
  - State RECV; mask, counters and buffer all 0.
- Bit event is recognised SYNC_STAGES+1 fpga_clk cycles after the pi_clk rise.
- pi_clk high and low phases must each be ≥SYNC_STAGES+2 fpga_clk cycles; faster input is unsupported.
- Final bit event of a pixel writes mask and features on the same edge, then clears the buffer.
- Final pixel of a frame: the next cycle is SCAN. SCAN lasts ROWS−3 cycles. result_valid rises on the cycle after the last SCAN cycle.
- result_ready high while result_valid=1 completes the handshake on that edge. result_valid falls and busy falls on the next cycle.
- result_ready high while result_valid=0 is ignored.
- rst_n low mid-frame or mid-scan aborts immediately. No partial result is emitted.

## Configuration
- RPS_HUE_WRAP_EN defined: if HUE_MIN>HUE_MAX, the band is hue≥HUE_MIN OR hue≤HUE_MAX (wrap-around band).
- Not defined: the band is strictly HUE_MIN≤hue≤HUE_MAX. If HUE_MIN>HUE_MAX the band is empty and every pixel masks to 1.
- Either way, HUE_MIN≤HUE_MAX behaves identically.

## Test plan
- Reset: hold rst_n=0 with random pi_clk -> all outputs at reset values; no bit event is recorded.
- All-green frame (H=50,S=100,V=100 every pixel) -> mask all 0, sum_left=0, trans=0 -> result=00; after ready, breadboard=110.
- Left columns 0..23 all hand in rows 0..39 -> sum_left=960>48 -> result=01; breadboard=101 after handshake.
- Hand in cols 10..59 with probe column 14 alternating hand/background in row bands giving exactly 4 transitions over rows 2..39 -> result=10; breadboard=011.
- Hold result_ready=0 for 100 cycles, then toggle pi_clk -> result stable, overrun=1, busy=1; after ready, the next frame classifies normally.
- rst_n pulse after 1200 pixels, then a full rock frame -> no result before reset; result=00 after the new frame.

Source files
------------

// File: rtl/rps_frame_classifier.sv
// rps_frame_classifier: bit-serial HSV pixel stream -> hand mask -> rock/paper/scissors.
// Pixels arrive LSB-first on pi_clk/data_in, are synchronised into fpga_clk,
// thresholded into a ROWS x COLS mask while streaming, then a column scan
// counts transitions and the result is offered with a valid/ready handshake.
// Ports: fpga_clk, rst_n (async active-low), pi_clk, data_in, result_ready;
//        result[1:0], result_valid, breadboard[2:0] (active-low), busy, overrun.
// Option: define RPS_HUE_WRAP_EN to treat HUE_MIN>HUE_MAX as a wrap-around band.
module rps_frame_classifier #(
    parameter int ROWS         = 40,
    parameter int COLS         = 60,
    parameter int CH_BITS      = 8,
    parameter int HUE_MIN      = 36,
    parameter int HUE_MAX      = 86,
    parameter int SAT_MIN      = 25,
    parameter int VAL_MIN      = 25,
    parameter int LEFT_COLS    = 24,
    parameter int SHIFT        = 4,
    parameter int TRANS_TARGET = 4,
    parameter int LEFT_THRESH  = 48,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       fpga_clk,
    input  logic       rst_n,
    input  logic       pi_clk,
    input  logic       data_in,
    input  logic       result_ready,
    output logic [1:0] result,
    output logic       result_valid,
    output logic [2:0] breadboard,
    output logic       busy,
    output logic       overrun
);
    localparam int NPIX = ROWS * COLS;
    localparam int PB   = 3 * CH_BITS;
    localparam int IW   = $clog2(NPIX);
    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);
    localparam int BW   = $clog2(PB);
    localparam int SLW  = $clog2(ROWS * LEFT_COLS + 1);
    localparam int TW   = $clog2(ROWS);

    typedef enum logic [1:0] {RECV, SCAN, RESULT} state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] pi_sync_q, din_sync_q;
    logic                 pi_prev_q;
    logic [PB-1:0]        pix_q, pix_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [NPIX-1:0]      mask_q, mask_d;
    logic [RW-1:0]        row_q, row_d;
    logic [CW-1:0]        col_q, col_d;
    logic [SLW-1:0]       sum_left_q, sum_left_d;
    logic [CW-1:0]        leftmost_q, leftmost_d;
    logic [RW-1:0]        scan_i_q, scan_i_d;
    logic [TW-1:0]        trans_q, trans_d;
    logic [1:0]           result_q, result_d;
    logic [2:0]           bb_q, bb_d;
    logic                 overrun_q, overrun_d;

    logic                 bit_evt, bit_val;
    logic [PB-1:0]        pix_full;
    logic [CH_BITS-1:0]   hue, sat, val;
    logic                 in_band, px_mask;
    logic [IW-1:0]        wr_idx, rd_a, rd_b;
    int                   p_int;
    logic [TW-1:0]        trans_inc;
    logic [1:0]           cls;

    // Edge detect on the last sync stage; data is taken from the same stage.
    assign bit_evt = pi_sync_q[SYNC_STAGES-1] & ~pi_prev_q;
    assign bit_val = din_sync_q[SYNC_STAGES-1];

    always_comb begin
        pix_full = {bit_val, pix_q[PB-2:0]};
        hue = pix_full[CH_BITS-1:0];
        sat = pix_full[2*CH_BITS-1:CH_BITS];
        val = pix_full[PB-1:2*CH_BITS];
`ifdef RPS_HUE_WRAP_EN
        if (HUE_MIN > HUE_MAX)
            in_band = (hue >= CH_BITS'(HUE_MIN)) || (hue <= CH_BITS'(HUE_MAX));
        else
            in_band = (hue >= CH_BITS'(HUE_MIN)) && (hue <= CH_BITS'(HUE_MAX));
`else
        in_band = (hue >= CH_BITS'(HUE_MIN)) && (hue <= CH_BITS'(HUE_MAX));
`endif
        px_mask = ~(in_band && (sat >= CH_BITS'(SAT_MIN)) && (val >= CH_BITS'(VAL_MIN)));
        wr_idx = IW'(int'(row_q) * COLS + int'(col_q));

        p_int = int'(leftmost_q) + SHIFT;
        if (p_int > COLS - 1) p_int = COLS - 1;
        rd_a = IW'(int'(scan_i_q) * COLS + p_int);
        rd_b = IW'((int'(scan_i_q) + 1) * COLS + p_int);
        trans_inc = trans_q + TW'(mask_q[rd_a] != mask_q[rd_b]);

        if (trans_inc == TW'(TRANS_TARGET))       cls = 2'b10;
        else if (sum_left_q > SLW'(LEFT_THRESH))  cls = 2'b01;
        else                                      cls = 2'b00;
    end

    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        bit_idx_d  = bit_idx_q;
        mask_d     = mask_q;
        row_d      = row_q;
        col_d      = col_q;
        sum_left_d = sum_left_q;
        leftmost_d = leftmost_q;
        scan_i_d   = scan_i_q;
        trans_d    = trans_q;
        result_d   = result_q;
        bb_d       = bb_q;
        overrun_d  = overrun_q;

        if (bit_evt && state_q != RECV) overrun_d = 1'b1;

        case (state_q)
            RECV: begin
                if (bit_evt) begin
                    if (bit_idx_q == BW'(PB - 1)) begin
                        mask_d[wr_idx] = px_mask;
                        if (px_mask && int'(col_q) < LEFT_COLS)
                            sum_left_d = sum_left_q + SLW'(1);
                        if (px_mask && col_q < leftmost_q)
                            leftmost_d = col_q;
                        pix_d     = '0;
                        bit_idx_d = '0;
                        if (col_q == CW'(COLS - 1)) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                            if (row_q == RW'(ROWS - 1)) begin
                                row_d    = '0;
                                scan_i_d = RW'(2);
                                state_d  = SCAN;
                            end
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else begin
                        pix_d[bit_idx_q] = bit_val;
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
            end
            SCAN: begin
                trans_d  = trans_inc;
                scan_i_d = scan_i_q + RW'(1);
                if (scan_i_q == RW'(ROWS - 2)) begin
                    result_d = cls;
                    state_d  = RESULT;
                end
            end
            RESULT: begin
                if (result_ready) begin
                    case (result_q)
                        2'b00:   bb_d = 3'b110;
                        2'b01:   bb_d = 3'b101;
                        default: bb_d = 3'b011;
                    endcase
                    // Fresh frame: everything the stream builds starts over.
                    mask_d     = '0;
                    pix_d      = '0;
                    bit_idx_d  = '0;
                    row_d      = '0;
                    col_d      = '0;
                    sum_left_d = '0;
                    leftmost_d = CW'(COLS - 1);
                    scan_i_d   = '0;
                    trans_d    = '0;
                    state_d    = RECV;
                end
            end
            default: state_d = RECV;
        endcase
    end

    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            pi_sync_q  <= '0;
            din_sync_q <= '0;
            pi_prev_q  <= 1'b0;
            state_q    <= RECV;
            pix_q      <= '0;
            bit_idx_q  <= '0;
            mask_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            sum_left_q <= '0;
            leftmost_q <= CW'(COLS - 1);
            scan_i_q   <= '0;
            trans_q    <= '0;
            result_q   <= 2'b00;
            bb_q       <= 3'b111;
            overrun_q  <= 1'b0;
        end else begin
            pi_sync_q  <= {pi_sync_q[SYNC_STAGES-2:0], pi_clk};
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], data_in};
            pi_prev_q  <= pi_sync_q[SYNC_STAGES-1];
            state_q    <= state_d;
            pix_q      <= pix_d;
            bit_idx_q  <= bit_idx_d;
            mask_q     <= mask_d;
            row_q      <= row_d;
            col_q      <= col_d;
            sum_left_q <= sum_left_d;
            leftmost_q <= leftmost_d;
            scan_i_q   <= scan_i_d;
            trans_q    <= trans_d;
            result_q   <= result_d;
            bb_q       <= bb_d;
            overrun_q  <= overrun_d;
        end
    end

    assign result       = result_q;
    assign result_valid = (state_q == RESULT);
    assign busy         = (state_q != RECV);
    assign breadboard   = bb_q;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_rps_frame_classifier.sv
// tb_rps_frame_classifier: drives serial HSV frames into a reduced-size classifier
// and compares every result against a reference model of the frame rules.
module tb_rps_frame_classifier;
    localparam int ROWS = 6, COLS = 5, CH = 4;
    localparam int HMIN = 3, HMAX = 9, SMIN = 2, VMIN = 2;
    localparam int LCOLS = 2, SHIFT = 1, TTARGET = 2, LTHRESH = 6;
    localparam int NPIX = ROWS * COLS, PB = 3 * CH;

    logic       fpga_clk = 1'b0;
    logic       rst_n, pi_clk, data_in, result_ready;
    logic [1:0] result;
    logic       result_valid, busy, overrun;
    logic [2:0] breadboard;

    always #5 fpga_clk = ~fpga_clk;

    rps_frame_classifier #(
        .ROWS(ROWS), .COLS(COLS), .CH_BITS(CH),
        .HUE_MIN(HMIN), .HUE_MAX(HMAX), .SAT_MIN(SMIN), .VAL_MIN(VMIN),
        .LEFT_COLS(LCOLS), .SHIFT(SHIFT), .TRANS_TARGET(TTARGET),
        .LEFT_THRESH(LTHRESH), .SYNC_STAGES(2)
    ) dut (
        .fpga_clk(fpga_clk), .rst_n(rst_n), .pi_clk(pi_clk),
        .data_in(data_in), .result_ready(result_ready), .result(result),
        .result_valid(result_valid), .breadboard(breadboard),
        .busy(busy), .overrun(overrun)
    );

    int n_cmp = 0, n_bad = 0;
    logic [PB-1:0] frame [NPIX];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PB-1:0] mk_px(input bit hand);
        logic [CH-1:0] h, s, v;
        h = CH'($urandom_range(HMAX, HMIN));
        s = CH'($urandom_range(15, SMIN));
        v = CH'($urandom_range(15, VMIN));
        if (hand) begin
            case ($urandom_range(2, 0))
                0: h = $urandom_range(1, 0) ? CH'($urandom_range(HMIN - 1, 0))
                                            : CH'($urandom_range(15, HMAX + 1));
                1: s = CH'($urandom_range(SMIN - 1, 0));
                default: v = CH'($urandom_range(VMIN - 1, 0));
            endcase
        end
        return {v, s, h};
    endfunction

    function automatic bit is_hand(input logic [PB-1:0] w);
        int h, s, v;
        h = int'(w[CH-1:0]);
        s = int'(w[2*CH-1:CH]);
        v = int'(w[PB-1:2*CH]);
        return !(h >= HMIN && h <= HMAX && s >= SMIN && v >= VMIN);
    endfunction

    function automatic logic [1:0] model_class();
        bit m [ROWS][COLS];
        int sum, left, p, tr;
        sum = 0;
        left = COLS - 1;
        tr = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                m[r][c] = is_hand(frame[r*COLS+c]);
                if (m[r][c] && c < LCOLS) sum++;
                if (m[r][c] && c < left) left = c;
            end
        p = (left + SHIFT > COLS - 1) ? COLS - 1 : left + SHIFT;
        for (int i = 2; i <= ROWS - 2; i++)
            if (m[i][p] != m[i+1][p]) tr++;
        if (tr == TTARGET) return 2'b10;
        if (sum > LTHRESH) return 2'b01;
        return 2'b00;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge fpga_clk);
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        cyc(1);
        pi_clk = 1'b1;
        cyc(4);
        pi_clk = 1'b0;
        cyc(4);
    endtask

    task automatic send_pixels(input int n);
        for (int p = 0; p < n; p++)
            for (int k = 0; k < PB; k++)
                send_bit(frame[p][k]);
    endtask

    task automatic wait_result(input string tag, input logic [1:0] cls);
        int t;
        t = 0;
        while (!result_valid && t < 100) begin
            cyc(1);
            t++;
        end
        chk({tag, "_valid"}, result_valid, 1'b1);
        chk({tag, "_result"}, result, cls);
        chk({tag, "_busy"}, busy, 1'b1);
    endtask

    task automatic handshake(input string tag, input logic [1:0] cls);
        logic [2:0] bb;
        bb = ~(3'b001 << cls);
        cyc($urandom_range(3, 0));
        chk({tag, "_hold"}, result, cls);
        result_ready = 1'b1;
        cyc(1);
        result_ready = 1'b0;
        chk({tag, "_vfall"}, result_valid, 1'b0);
        chk({tag, "_bfall"}, busy, 1'b0);
        chk({tag, "_bb"}, breadboard, bb);
    endtask

    task automatic run_frame(input string tag);
        logic [1:0] cls;
        cls = model_class();
        send_pixels(NPIX);
        wait_result(tag, cls);
        handshake(tag, cls);
    endtask

    task automatic fill_random();
        int ph;
        ph = $urandom_range(80, 10);
        for (int i = 0; i < NPIX; i++)
            frame[i] = mk_px($urandom_range(99, 0) < ph);
    endtask

    initial begin
        logic [1:0] cls;
        rst_n = 1'b0;
        pi_clk = 1'b0;
        data_in = 1'b0;
        result_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pi_clk = 1'($urandom);
            data_in = 1'($urandom);
            cyc(1);
        end
        chk("rst_result", result, 2'b00);
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_bb", breadboard, 3'b111);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        pi_clk = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(5);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_overrun", overrun, 1'b0);

        for (int i = 0; i < NPIX; i++) frame[i] = {4'd8, 4'd8, 4'd5};
        chk("model_green", model_class(), 2'b00);
        run_frame("green");

        for (int i = 0; i < NPIX; i++) frame[i] = mk_px((i % COLS) < LCOLS);
        chk("model_left", model_class(), 2'b01);
        run_frame("left");

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                frame[r*COLS+c] = mk_px(c >= 1 && !(c == 2 && r == 3));
        chk("model_sciss", model_class(), 2'b10);
        run_frame("sciss");

        fill_random();
        cls = model_class();
        send_pixels(NPIX);
        wait_result("stall", cls);
        for (int k = 0; k < 4; k++) begin
            cyc(25);
            chk("stall_stable", result, cls);
            chk("stall_valid", result_valid, 1'b1);
        end
        send_bit(1'b1);
        chk("stall_overrun", overrun, 1'b1);
        chk("stall_busy", busy, 1'b1);
        chk("stall_result", result, cls);
        handshake("stall", cls);

        fill_random();
        run_frame("after_stall");
        chk("overrun_sticky", overrun, 1'b1);

        for (int i = 0; i < NPIX; i++) frame[i] = mk_px(1'b0);
        send_pixels(NPIX / 2);
        chk("abort_valid", result_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        rst_n = 1'b0;
        cyc(2);
        chk("abort_overrun", overrun, 1'b0);
        chk("abort_bb", breadboard, 3'b111);
        chk("abort_valid2", result_valid, 1'b0);
        rst_n = 1'b1;
        cyc(3);
        run_frame("rock");

        for (int f = 0; f < 3; f++) begin
            fill_random();
            run_frame("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
